// File: rtl/matrix_tile_rf_pkg.sv
// Shared types and sizes for the matrix tile register file
// and its tile load/store sequencer.
package matrix_tile_rf_pkg;
    localparam int NUM_TILES = 4;
    localparam int TILE_W    = 128;
    localparam int BEAT_W    = 32;
    localparam int IDX_W     = $clog2(NUM_TILES);
    localparam int NUM_BEATS = TILE_W / BEAT_W;

    typedef logic [IDX_W-1:0] tile_idx_t;

    typedef enum logic [1:0] {
        ML_IDLE,
        ML_XFER,
        ML_DONE
    } ml_state_t;
endpackage

// File: rtl/matrix_tile_rf_seq.sv
// Tile transfer sequencer: FSM, beat counter, staging tile
// and the memory-side beat interface.
module matrix_tile_seq #(
    parameter int TILE_W = matrix_tile_rf_pkg::TILE_W,
    parameter int BEAT_W = matrix_tile_rf_pkg::BEAT_W,
    parameter int IDX_W  = matrix_tile_rf_pkg::IDX_W,
    localparam int NB    = TILE_W / BEAT_W,
    localparam int CNT_W = $clog2(NB)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ml_start,
    input  logic              ml_store,
    input  logic [IDX_W-1:0]  ml_tile,
    input  logic [TILE_W-1:0] snap_data,
    output logic              ml_busy,
    output logic              ml_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [CNT_W-1:0]  mem_beat,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              xfer_load,
    output logic [IDX_W-1:0]  cur_tile,
    output logic              commit_we,
    output logic [TILE_W-1:0] commit_data
);
    import matrix_tile_rf_pkg::*;

    ml_state_t         r_state;
    ml_state_t         w_next;
    logic              r_store;
    logic [IDX_W-1:0]  r_tile;
    logic [CNT_W-1:0]  r_cnt;
    logic [TILE_W-1:0] r_stage;
    logic              w_xfer;
    logic              w_ack;
    logic              w_last;

    assign w_xfer = (r_state == ML_XFER);
    assign w_ack  = w_xfer && mem_ack;
    assign w_last = (r_cnt == CNT_W'(NB - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ML_IDLE;
            r_store <= 1'b0;
            r_tile  <= '0;
            r_cnt   <= '0;
            r_stage <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ML_IDLE && ml_start) begin
                r_store <= ml_store;
                r_tile  <= ml_tile;
                r_cnt   <= '0;
                if (ml_store)
                    r_stage <= snap_data;
            end else if (w_ack) begin
                r_cnt <= r_cnt + 1'b1;
                if (!r_store)
                    r_stage[r_cnt*BEAT_W +: BEAT_W] <= mem_rdata;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ML_IDLE: if (ml_start) w_next = ML_XFER;
            ML_XFER: if (w_ack && w_last) w_next = ML_DONE;
            ML_DONE: w_next = ML_IDLE;
            default: w_next = ML_IDLE;
        endcase
    end

    assign ml_busy   = (r_state != ML_IDLE);
    assign ml_done   = (r_state == ML_DONE);
    assign mem_req   = w_xfer;
    assign mem_we    = w_xfer && r_store;
    assign mem_beat  = w_xfer ? r_cnt : '0;
    assign mem_wdata = w_xfer ? r_stage[r_cnt*BEAT_W +: BEAT_W] : '0;
    assign xfer_load = w_xfer && !r_store;
    assign cur_tile  = r_tile;
    assign commit_we = w_ack && w_last && !r_store;

    // The last row is taken straight from the bus, not the staging register.
    always_comb begin
        commit_data = r_stage;
        commit_data[(NB-1)*BEAT_W +: BEAT_W] = mem_rdata;
    end
endmodule

// File: rtl/matrix_tile_rf.sv
// Matrix tile register file: tile array, write-first read bypass,
// load hazard stall, and the tile transfer sequencer.
module matrix_tile_rf #(
    parameter int NUM_TILES = matrix_tile_rf_pkg::NUM_TILES,
    parameter int TILE_W    = matrix_tile_rf_pkg::TILE_W,
    parameter int BEAT_W    = matrix_tile_rf_pkg::BEAT_W,
    localparam int IDX_W    = $clog2(NUM_TILES),
    localparam int CNT_W    = $clog2(TILE_W / BEAT_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_tile,
    output logic [TILE_W-1:0] op_matrix,
    output logic              stall_o,
    input  logic              wb_we,
    input  logic [IDX_W-1:0]  wb_tile,
    input  logic [TILE_W-1:0] matrix_i,
    input  logic              ml_start,
    input  logic              ml_store,
    input  logic [IDX_W-1:0]  ml_tile,
    output logic              ml_busy,
    output logic              ml_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [CNT_W-1:0]  mem_beat,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_ack
);
    import matrix_tile_rf_pkg::*;

    logic [TILE_W-1:0] r_tile [NUM_TILES];
    logic [TILE_W-1:0] w_snap;
    logic [TILE_W-1:0] w_commit_data;
    logic [IDX_W-1:0]  w_cur_tile;
    logic              w_xfer_load;
    logic              w_commit_we;

    assign w_snap = (wb_we && wb_tile == ml_tile) ? matrix_i
                                                  : r_tile[ml_tile];

    assign op_matrix = (wb_we && wb_tile == rd_tile) ? matrix_i
                                                     : r_tile[rd_tile];

    assign stall_o = rd_en && w_xfer_load && (rd_tile == w_cur_tile);

    // A load commit overrides a same-edge writeback to the same tile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_TILES; i++)
                r_tile[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_TILES; i++) begin
                if (w_commit_we && w_cur_tile == IDX_W'(i))
                    r_tile[i] <= w_commit_data;
                else if (wb_we && wb_tile == IDX_W'(i))
                    r_tile[i] <= matrix_i;
            end
        end
    end

    matrix_tile_seq #(
        .TILE_W (TILE_W),
        .BEAT_W (BEAT_W),
        .IDX_W  (IDX_W)
    ) u_seq (
        .clk         (clk),
        .rst         (rst),
        .ml_start    (ml_start),
        .ml_store    (ml_store),
        .ml_tile     (ml_tile),
        .snap_data   (w_snap),
        .ml_busy     (ml_busy),
        .ml_done     (ml_done),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_beat    (mem_beat),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .xfer_load   (w_xfer_load),
        .cur_tile    (w_cur_tile),
        .commit_we   (w_commit_we),
        .commit_data (w_commit_data)
    );
endmodule

// File: tb/tb_matrix_tile_rf.sv
// Scoreboard bench for matrix_tile_rf: stimulus queues expected
// beats, done pulses and reads; a negedge monitor checks them.
module tb_matrix_tile_rf;
    import matrix_tile_rf_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_en;
    tile_idx_t    rd_tile;
    logic [127:0] op_matrix;
    logic         stall_o;
    logic         wb_we;
    tile_idx_t    wb_tile;
    logic [127:0] matrix_i;
    logic         ml_start;
    logic         ml_store;
    tile_idx_t    ml_tile;
    logic         ml_busy;
    logic         ml_done;
    logic         mem_req;
    logic         mem_we;
    logic [1:0]   mem_beat;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_ack;
    logic [31:0]  ld_data [4];

    matrix_tile_rf dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .rd_tile   (rd_tile),
        .op_matrix (op_matrix),
        .stall_o   (stall_o),
        .wb_we     (wb_we),
        .wb_tile   (wb_tile),
        .matrix_i  (matrix_i),
        .ml_start  (ml_start),
        .ml_store  (ml_store),
        .ml_tile   (ml_tile),
        .ml_busy   (ml_busy),
        .ml_done   (ml_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_beat  (mem_beat),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    // The bench plays memory: each beat returns its row from ld_data.
    assign mem_rdata = ld_data[mem_beat];

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic        we;
        logic [1:0]  beat;
        logic [31:0] wd;
        int          cy;
    } beat_t;

    typedef struct {
        logic [127:0] d;
        logic         st;
    } rd_t;

    beat_t beat_q[$];
    int    done_q[$];
    rd_t   rd_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic bad(string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at cycle %0d", nm, cyc);
    endtask

    beat_t mb;
    rd_t   mr;
    int    md;
    always @(negedge clk) begin
        if (mem_req && mem_ack) begin
            if (beat_q.size() == 0) begin
                bad("spurious_beat");
            end else begin
                mb = beat_q.pop_front();
                chk("beat_idx", mem_beat, mb.beat);
                chk("beat_we", mem_we, mb.we);
                chk("beat_cycle", cyc, mb.cy);
                if (mb.we)
                    chk("beat_wdata", mem_wdata, mb.wd);
            end
        end
        if (ml_done) begin
            if (done_q.size() == 0) begin
                bad("spurious_done");
            end else begin
                md = done_q.pop_front();
                chk("done_cycle", cyc, md);
            end
        end
        if (rd_en) begin
            if (rd_q.size() == 0) begin
                bad("unexpected_read");
            end else begin
                mr = rd_q.pop_front();
                chk("rd_data", op_matrix, mr.d);
                chk("rd_stall", stall_o, mr.st);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rd_en    = 1'b0;
        wb_we    = 1'b0;
        ml_start = 1'b0;
    endtask

    task automatic rd(tile_idx_t t, logic [127:0] d, logic st);
        rd_en   = 1'b1;
        rd_tile = t;
        rd_q.push_back('{d: d, st: st});
    endtask

    task automatic start(logic st, tile_idx_t t, output int c0);
        ml_start = 1'b1;
        ml_store = st;
        ml_tile  = t;
        c0       = cyc;
    endtask

    localparam logic [127:0] LD2 =
        128'h100F0E0D_0C0B0A09_08070605_04030201;
    localparam logic [127:0] LD0 =
        128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] BYP =
        128'h01234567_89ABCDEF_FEDCBA98_76543210;

    initial begin
        #100000;
        $display("FAIL watchdog: bench timed out");
        $fatal(1);
    end

    initial begin
        int c0;
        rst = 1'b1;
        clr();
        rd_tile  = '0;
        wb_tile  = '0;
        matrix_i = '0;
        ml_store = 1'b0;
        ml_tile  = '0;
        mem_ack  = 1'b0;
        ld_data  = '{32'h0, 32'h0, 32'h0, 32'h0};
        tick();
        tick();
        chk("rst_busy", ml_busy, 0);
        chk("rst_done", ml_done, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_beat", mem_beat, 0);
        chk("rst_wdata", mem_wdata, 0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            clr();
            rd(tile_idx_t'(i), '0, 1'b0);
            tick();
        end

        // Zero-wait load of tile 2 with a reader stalled on it.
        clr();
        ld_data = '{32'h04030201, 32'h08070605,
                    32'h0C0B0A09, 32'h100F0E0D};
        mem_ack = 1'b1;
        start(1'b0, 2'd2, c0);
        for (int k = 0; k < 4; k++)
            beat_q.push_back('{1'b0, 2'(k), 32'h0, c0 + 1 + k});
        done_q.push_back(c0 + 5);
        tick();
        chk("load_busy", ml_busy, 1);
        for (int k = 1; k <= 4; k++) begin
            clr();
            rd(2'd2, '0, 1'b1);
            tick();
        end
        clr();
        rd(2'd2, LD2, 1'b0);
        tick();
        clr();
        chk("load_idle", ml_busy, 0);

        // Store tile 1 with a wait cycle per beat and a mid-store writeback.
        wb_we    = 1'b1;
        wb_tile  = 2'd1;
        matrix_i = {16{8'hAA}};
        tick();
        clr();
        mem_ack = 1'b0;
        start(1'b1, 2'd1, c0);
        for (int k = 0; k < 4; k++)
            beat_q.push_back('{1'b1, 2'(k), 32'hAAAAAAAA, c0 + 2 + 2*k});
        done_q.push_back(c0 + 9);
        tick();
        for (int k = 1; k <= 8; k++) begin
            clr();
            mem_ack = (k % 2 == 0);
            if (k == 1)
                rd(2'd1, {16{8'hAA}}, 1'b0);
            if (k == 2) begin
                wb_we    = 1'b1;
                wb_tile  = 2'd1;
                matrix_i = {16{8'h55}};
            end
            if (k == 3)
                rd(2'd1, {16{8'h55}}, 1'b0);
            tick();
        end
        clr();
        mem_ack = 1'b1;
        tick();
        clr();
        rd(2'd1, {16{8'h55}}, 1'b0);
        tick();

        // Same-cycle bypass, then the registered value.
        clr();
        wb_we    = 1'b1;
        wb_tile  = 2'd3;
        matrix_i = BYP;
        rd(2'd3, BYP, 1'b0);
        tick();
        clr();
        rd(2'd3, BYP, 1'b0);
        tick();

        // Load of tile 0 colliding with a writeback at the commit edge.
        clr();
        ld_data = '{32'h11111111, 32'h22222222,
                    32'h33333333, 32'h44444444};
        start(1'b0, 2'd0, c0);
        for (int k = 0; k < 4; k++)
            beat_q.push_back('{1'b0, 2'(k), 32'h0, c0 + 1 + k});
        done_q.push_back(c0 + 5);
        tick();
        for (int k = 1; k <= 4; k++) begin
            clr();
            rd(2'd1, {16{8'h55}}, 1'b0);
            if (k == 4) begin
                wb_we    = 1'b1;
                wb_tile  = 2'd0;
                matrix_i = {16{8'hEE}};
            end
            tick();
        end
        clr();
        rd(2'd0, LD0, 1'b0);
        tick();

        // Reset in cycle 2 of a load into tile 0.
        clr();
        tick();
        start(1'b0, 2'd0, c0);
        beat_q.push_back('{1'b0, 2'd0, 32'h0, c0 + 1});
        tick();
        clr();
        tick();
        rst = 1'b1;
        #1;
        chk("abort_req", mem_req, 0);
        chk("abort_busy", ml_busy, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++)
            tick();
        clr();
        chk("abort_idle", ml_busy, 0);
        rd(2'd0, '0, 1'b0);
        tick();
        clr();
        tick();

        chk("beat_q_left", beat_q.size(), 0);
        chk("done_q_left", done_q.size(), 0);
        chk("rd_q_left", rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
